// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer port arbiter.
// The writer FSM state, default image geometry, and the frame size helper live here.
package fb_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    HOLD  = 1'b1
  } fbState_t;

  localparam int WIDTH_DEF = 128;
  localparam int DEPTH_DEF = 128;
  localparam int PIX_W_DEF = 8;

  // Pixels per frame at the default geometry.
  localparam int FRAME_PIX = WIDTH_DEF * DEPTH_DEF;

  // Pixels per frame for an arbitrary geometry.
  function automatic int framePix(input int w, input int d);
    return w * d;
  endfunction

endpackage

// File: rtl/fb_read_pipe.sv
// Display read pipeline: carries the image-region hit flag alongside the
// BRAM read so the pixel appears two cycles after its coordinate. Blanks
// the pixel to zero outside the image region.
module fb_read_pipe
  import fb_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispHit,
  input  logic [PIX_W-1:0] memRdata,
  output logic [PIX_W-1:0] pixOut,
  output logic             pixValid
);

  logic hitD1;

  // Two-stage hit delay; the second stage registers the BRAM data with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hitD1    <= 1'b0;
      pixValid <= 1'b0;
      pixOut   <= '0;
    end else begin
      hitD1    <= dispHit;
      pixValid <= hitD1;
      pixOut   <= hitD1 ? memRdata : '0;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one BRAM port between the VGA reader
// (absolute priority) and a valid/ready pixel writer.
// Build option FB_DOUBLE_BUF_EN: when defined, two banks are used and the
// writer fills the back bank, swapping at frame_start once a frame is
// complete. When undefined, a single bank is written continuously.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int AW    = $clog2(WIDTH * DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [9:0]       disp_x,
  input  logic [9:0]       disp_y,
  input  logic             disp_active,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             wr_valid,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_last,
  output logic             wr_ready,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic             front_bank,
  output logic             frame_err
);

  // Index bits within one bank; the address MSB selects the bank.
  localparam int IW        = AW - 1;
  localparam int FRAME_LEN = framePix(WIDTH, DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  fbState_t      state;
  fbState_t      stateNext;
  logic [IW-1:0] wrIdx;
  logic [IW-1:0] wrIdxNext;
  logic          frontBank;
  logic          frontBankNext;
  logic          frameErr;
  logic          frameErrNext;

  logic          dispHit;
  logic [IW-1:0] dispIdx;
  logic          accept;
  logic          atLast;
  logic          backBank;

  assign dispHit = disp_active && (32'(disp_x) < WIDTH) && (32'(disp_y) < DEPTH);
  assign dispIdx = IW'(disp_y) * IW'(WIDTH) + IW'(disp_x);
  assign atLast  = (wrIdx == LAST_IDX);

`ifdef FB_DOUBLE_BUF_EN
  assign backBank = ~frontBank;
`else
  // Single bank: everything lives in bank 0 and frame_start has no effect.
  logic unusedFrameStart;
  assign unusedFrameStart = frame_start;
  assign backBank         = 1'b0;
`endif

  assign front_bank = frontBank;
  assign frame_err  = frameErr;

  // State register: writer FSM, write index, displayed bank, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WRITE;
      wrIdx     <= '0;
      frontBank <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state     <= stateNext;
      wrIdx     <= wrIdxNext;
      frontBank <= frontBankNext;
      frameErr  <= frameErrNext;
    end
  end

  // Next-state logic: advance on accepted writes, close the frame, swap banks.
  always_comb begin
    stateNext     = state;
    wrIdxNext     = wrIdx;
    frontBankNext = frontBank;
    frameErrNext  = frameErr;
    case (state)
      WRITE: begin
        if (accept) begin
          // wr_last must coincide exactly with the final pixel index.
          if (wr_last != atLast) begin
            frameErrNext = 1'b1;
          end
          if (wr_last || atLast) begin
`ifdef FB_DOUBLE_BUF_EN
            stateNext = HOLD;
`else
            wrIdxNext = '0;
`endif
          end else begin
            wrIdxNext = wrIdx + IW'(1);
          end
        end
      end
      HOLD: begin
`ifdef FB_DOUBLE_BUF_EN
        if (frame_start) begin
          frontBankNext = ~frontBank;
          wrIdxNext     = '0;
          stateNext     = WRITE;
        end
`else
        stateNext = WRITE;
`endif
      end
      default: stateNext = WRITE;
    endcase
  end

  // Port outputs: the display owns the port inside the image region.
  always_comb begin
    wr_ready  = (state == WRITE) && !dispHit;
    accept    = wr_valid && wr_ready;
    mem_we    = accept;
    mem_wdata = wr_data;
    if (dispHit) begin
      mem_addr = {frontBank, dispIdx};
    end else begin
      mem_addr = {backBank, wrIdx};
    end
  end

  fb_read_pipe #(
    .PIX_W(PIX_W)
  ) readPipe (
    .clk     (clk),
    .reset   (reset),
    .dispHit (dispHit),
    .memRdata(mem_rdata),
    .pixOut  (pix_out),
    .pixValid(pix_valid)
  );

endmodule
